// File: rtl/wide_reg_pkg.sv
// Shared types and helpers for the wide register loader.
package wide_reg_pkg;

    localparam int unsigned MAX_WORDS = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2
    } loader_state_t;

    // One-hot slot enable; all zero when no write happens this cycle.
    function automatic logic [MAX_WORDS-1:0] slot_enable(input int unsigned cnt, input logic write);
        logic [MAX_WORDS-1:0] v;
        v = '0;
        if (write && (cnt < MAX_WORDS)) begin
            v = {{(MAX_WORDS-1){1'b0}}, 1'b1} << cnt;
        end
        return v;
    endfunction

endpackage

// File: rtl/wide_reg_if.sv
// Narrow input stream, wide output handshake and status for the wide register loader.
interface wide_reg_if #(
    parameter int unsigned IN_WIDTH  = 64,
    parameter int unsigned NUM_WORDS = 4
) ();
    localparam int unsigned CNT_W     = $clog2(NUM_WORDS);
    localparam int unsigned OUT_WIDTH = IN_WIDTH * NUM_WORDS;

    logic                 start;
    logic                 abort;
    logic                 in_valid;
    logic                 in_ready;
    logic [IN_WIDTH-1:0]  in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_WIDTH-1:0] out_data;
    logic                 busy;
    logic [CNT_W-1:0]     word_cnt;

    modport master (
        output start, abort, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy, word_cnt
    );

    modport slave (
        input  start, abort, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy, word_cnt
    );
endinterface

// File: rtl/wide_reg_slot.sv
// One enable-gated word register with synchronous reset and clear.
module wide_reg_slot #(
    parameter int unsigned W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/wide_reg_loader.sv
// Assembles NUM_WORDS narrow beats into one wide word and holds it for a consumer handshake.
module wide_reg_loader
    import wide_reg_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = 64,
    parameter int unsigned NUM_WORDS = 4
) (
    input  logic     clk,
    input  logic     rst,
    wide_reg_if.slave bus
);

    localparam int unsigned      CNT_W = $clog2(NUM_WORDS);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(NUM_WORDS - 1);

    loader_state_t        state;
    loader_state_t        state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_nxt;
    logic                 in_ready_q;
    logic                 out_valid_q;
    logic                 busy_q;
    logic                 accept;
    logic                 xfer;
    logic [MAX_WORDS-1:0] en_full;
    logic [NUM_WORDS-1:0] en;
    logic                 unused_en;

    assign accept = bus.in_valid && in_ready_q;
    assign xfer   = bus.out_ready && out_valid_q;

    // A beat arriving alongside abort is dropped.
    assign en_full   = slot_enable(32'(cnt), accept && !bus.abort);
    assign en        = en_full[NUM_WORDS-1:0];
    assign unused_en = ^en_full;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (bus.abort) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state_nxt = LOAD;
                        cnt_nxt   = '0;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        if (cnt == LAST) begin
                            state_nxt = HOLD;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = cnt + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (xfer) begin
                        state_nxt = bus.start ? LOAD : IDLE;
                        cnt_nxt   = '0;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Handshake flags are registered alongside the state so no input reaches them combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            in_ready_q  <= (state_nxt == LOAD);
            out_valid_q <= (state_nxt == HOLD);
            busy_q      <= (state_nxt != IDLE);
        end
    end

    genvar k;
    generate
        for (k = 0; k < NUM_WORDS; k++) begin : g_slot
            wide_reg_slot #(.W(IN_WIDTH)) u_slot (
                .clk (clk),
                .rst (rst),
                .clr (bus.abort),
                .en  (en[k]),
                .d   (bus.in_data),
                .q   (bus.out_data[k*IN_WIDTH +: IN_WIDTH])
            );
        end
    endgenerate

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.word_cnt  = cnt;

endmodule

// File: tb/tb_wide_reg_loader.sv
// Directed bench for wide_reg_loader: 4x64 and 3x32 builds.
module tb_wide_reg_loader;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    wide_reg_if #(.IN_WIDTH(64), .NUM_WORDS(4)) bus4 ();
    wide_reg_if #(.IN_WIDTH(32), .NUM_WORDS(3)) bus3 ();

    wide_reg_loader #(.IN_WIDTH(64), .NUM_WORDS(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    wide_reg_loader #(.IN_WIDTH(32), .NUM_WORDS(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

    localparam logic [63:0]  B1  = 64'h1111_1111_1111_1111;
    localparam logic [63:0]  B2  = 64'h2222_2222_2222_2222;
    localparam logic [63:0]  B3  = 64'h3333_3333_3333_3333;
    localparam logic [63:0]  B4  = 64'h4444_4444_4444_4444;
    localparam logic [63:0]  A0  = 64'hA0A0_A0A0_A0A0_A0A0;
    localparam logic [63:0]  A1  = 64'hA1A1_A1A1_A1A1_A1A1;
    localparam logic [63:0]  A2  = 64'hA2A2_A2A2_A2A2_A2A2;
    localparam logic [63:0]  A3  = 64'hA3A3_A3A3_A3A3_A3A3;
    localparam logic [255:0] W1  = 256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111;
    localparam logic [255:0] WA  = 256'hA3A3A3A3A3A3A3A3_A2A2A2A2A2A2A2A2_A1A1A1A1A1A1A1A1_A0A0A0A0A0A0A0A0;
    localparam logic [255:0] W3  = 256'h000000030000000200000001;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load4(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c, input logic [63:0] d);
        logic [63:0] bt [4];
        bt[0] = a; bt[1] = b; bt[2] = c; bt[3] = d;
        bus4.start = 1'b1;
        tick();
        bus4.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus4.in_valid = 1'b1;
            bus4.in_data  = bt[i];
            tick();
        end
        bus4.in_valid = 1'b0;
    endtask

    initial begin
        logic [63:0] beats [4];
        int          gaps  [4];
        logic [1:0]  ecnt  [4];
        beats[0] = B1; beats[1] = B2; beats[2] = B3; beats[3] = B4;
        gaps[0] = 0; gaps[1] = 2; gaps[2] = 0; gaps[3] = 3;
        ecnt[0] = 2'd1; ecnt[1] = 2'd2; ecnt[2] = 2'd3; ecnt[3] = 2'd0;

        rst = 1'b1;
        bus4.start = 1'b0; bus4.abort = 1'b0; bus4.in_valid = 1'b0; bus4.in_data = '0; bus4.out_ready = 1'b0;
        bus3.start = 1'b0; bus3.abort = 1'b0; bus3.in_valid = 1'b0; bus3.in_data = '0; bus3.out_ready = 1'b0;
        tick();
        tick();
        chk("rst_busy",     256'(bus4.busy),      256'd0);
        chk("rst_in_ready", 256'(bus4.in_ready),  256'd0);
        chk("rst_out_valid",256'(bus4.out_valid), 256'd0);
        chk("rst_word_cnt", 256'(bus4.word_cnt),  256'd0);
        chk("rst_out_data", 256'(bus4.out_data),  256'd0);
        rst = 1'b0;

        // Straight load with in_valid held high.
        bus4.start = 1'b1;
        tick();
        bus4.start = 1'b0;
        chk("t1_in_ready", 256'(bus4.in_ready), 256'd1);
        chk("t1_cnt0",     256'(bus4.word_cnt), 256'd0);
        for (int i = 0; i < 4; i++) begin
            bus4.in_valid = 1'b1;
            bus4.in_data  = beats[i];
            tick();
            chk($sformatf("t1_cnt%0d", i + 1), 256'(bus4.word_cnt), 256'(ecnt[i]));
            chk($sformatf("t1_ov%0d", i + 1),  256'(bus4.out_valid), 256'(i == 3));
        end
        bus4.in_valid = 1'b0;
        chk("t1_data",     256'(bus4.out_data), W1);
        chk("t1_hold_ir",  256'(bus4.in_ready), 256'd0);
        bus4.out_ready = 1'b1;
        tick();
        bus4.out_ready = 1'b0;
        chk("t1_idle_busy", 256'(bus4.busy),      256'd0);
        chk("t1_idle_ov",   256'(bus4.out_valid), 256'd0);
        chk("t1_idle_data", 256'(bus4.out_data),  W1);

        // Load with gaps on in_valid, then a stalled consumer.
        bus4.start = 1'b1;
        tick();
        bus4.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < gaps[i]; g++) begin
                bus4.in_valid = 1'b0;
                bus4.in_data  = 64'hDEAD_BEEF_DEAD_BEEF;
                tick();
                chk("t2_gap_cnt", 256'(bus4.word_cnt), 256'(i));
            end
            bus4.in_valid = 1'b1;
            bus4.in_data  = beats[i];
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            bus4.in_valid = 1'b1;
            bus4.in_data  = '1;
            bus4.start    = 1'b1;
            tick();
            chk("t2_hold_ov",   256'(bus4.out_valid), 256'd1);
            chk("t2_hold_data", 256'(bus4.out_data),  W1);
        end
        bus4.in_valid  = 1'b0;
        bus4.start     = 1'b0;
        bus4.out_ready = 1'b1;
        tick();
        bus4.out_ready = 1'b0;
        chk("t2_busy", 256'(bus4.busy), 256'd0);

        // Back-to-back: handshake together with start.
        load4(B1, B2, B3, B4);
        bus4.out_ready = 1'b1;
        bus4.start     = 1'b1;
        tick();
        bus4.out_ready = 1'b0;
        bus4.start     = 1'b0;
        chk("t3_in_ready", 256'(bus4.in_ready),  256'd1);
        chk("t3_busy",     256'(bus4.busy),      256'd1);
        chk("t3_ov",       256'(bus4.out_valid), 256'd0);
        chk("t3_cnt",      256'(bus4.word_cnt),  256'd0);
        beats[0] = A0; beats[1] = A1; beats[2] = A2; beats[3] = A3;
        for (int i = 0; i < 4; i++) begin
            bus4.in_valid = 1'b1;
            bus4.in_data  = beats[i];
            tick();
        end
        bus4.in_valid = 1'b0;
        chk("t3_ov2",  256'(bus4.out_valid), 256'd1);
        chk("t3_data", 256'(bus4.out_data),  WA);
        bus4.out_ready = 1'b1;
        tick();
        bus4.out_ready = 1'b0;

        // Abort after two beats with a beat presented in the abort cycle.
        bus4.start = 1'b1;
        tick();
        bus4.start = 1'b0;
        bus4.in_valid = 1'b1; bus4.in_data = B1; tick();
        bus4.in_valid = 1'b1; bus4.in_data = B2; tick();
        bus4.abort = 1'b1; bus4.in_valid = 1'b1; bus4.in_data = '1;
        tick();
        bus4.abort = 1'b0; bus4.in_valid = 1'b0;
        chk("t4_busy", 256'(bus4.busy),     256'd0);
        chk("t4_ir",   256'(bus4.in_ready), 256'd0);
        chk("t4_cnt",  256'(bus4.word_cnt), 256'd0);
        chk("t4_data", 256'(bus4.out_data), 256'd0);
        load4(B1, B2, B3, B4);
        chk("t4_reload", 256'(bus4.out_data), W1);
        bus4.out_ready = 1'b1;
        tick();
        bus4.out_ready = 1'b0;

        // Reset in LOAD after three beats.
        bus4.start = 1'b1;
        tick();
        bus4.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus4.in_valid = 1'b1;
            bus4.in_data  = A0;
            tick();
        end
        bus4.in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_load_busy", 256'(bus4.busy),     256'd0);
        chk("t5_load_ir",   256'(bus4.in_ready), 256'd0);
        chk("t5_load_cnt",  256'(bus4.word_cnt), 256'd0);
        chk("t5_load_data", 256'(bus4.out_data), 256'd0);

        // Reset in HOLD, then stray beats in IDLE.
        load4(B1, B2, B3, B4);
        chk("t5_hold_ov", 256'(bus4.out_valid), 256'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_rst_ov",   256'(bus4.out_valid), 256'd0);
        chk("t5_rst_data", 256'(bus4.out_data),  256'd0);
        chk("t5_rst_busy", 256'(bus4.busy),      256'd0);
        for (int i = 0; i < 3; i++) begin
            bus4.in_valid = 1'b1;
            bus4.in_data  = B4;
            tick();
        end
        bus4.in_valid = 1'b0;
        chk("t5_idle_data", 256'(bus4.out_data), 256'd0);
        chk("t5_idle_ir",   256'(bus4.in_ready), 256'd0);

        // Three-word, 32-bit build.
        bus3.start = 1'b1;
        tick();
        bus3.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus3.in_valid = 1'b1;
            bus3.in_data  = 32'(i + 1);
            tick();
            chk($sformatf("t6_cnt%0d", i + 1), 256'(bus3.word_cnt), 256'((i + 1) % 3));
        end
        bus3.in_valid = 1'b0;
        chk("t6_ov",   256'(bus3.out_valid), 256'd1);
        chk("t6_data", 256'(bus3.out_data),  W3);
        bus3.out_ready = 1'b1;
        tick();
        bus3.out_ready = 1'b0;
        chk("t6_busy", 256'(bus3.busy), 256'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
